avs_i2c_cmdq_top: RTL



---
 rtl/i2c_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/avs_i2c_cmdq_top.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the Avalon-MM I2C command-queue front-end:
// command opcodes, register addresses, STATUS bit positions and sequencer states.
package i2c_pkg;

    typedef enum logic [2:0] {
        OP_START = 3'd0,
        OP_STOP  = 3'd1,
        OP_WRITE = 3'd2,
        OP_RACK  = 3'd3,
        OP_RNACK = 3'd4
    } op_e;

    localparam logic [2:0] REG_RXDATA  = 3'd0;
    localparam logic [2:0] REG_CMD     = 3'd1;
    localparam logic [2:0] REG_CLKDIV  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_IRQEN   = 3'd5;

    localparam int ST_BUSY        = 0;
    localparam int ST_ACK_FAIL    = 1;
    localparam int ST_CMD_DONE    = 2;
    localparam int ST_RX_NONEMPTY = 3;
    localparam int ST_CMD_FULL    = 4;
    localparam int ST_RX_OVF      = 5;
    localparam int ST_CMD_OVF     = 6;
    localparam int ST_BAD_OP      = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_e;

    function automatic logic op_valid(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; level is kept separately from the wrapping
// pointers so a full FIFO and an empty FIFO are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push;

    assign empty = (r_level == '0);
    assign full  = (r_level == FULL_LEVEL);
    assign level = r_level;
    assign dout  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_pop  = pop && !empty && !flush;
    assign w_push = push && (!full || (pop && !empty)) && !flush;

    // NOTE: storage is deliberately not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    // NOTE: every sequential assignment is non-blocking so all state updates
    // see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/avs_i2c_cmdq_top.sv
// Avalon-MM front-end that queues I2C primitives for i2c_core, issues them one
// at a time, collects received bytes and raises a maskable level interrupt.
module avs_i2c_cmdq_top
    import i2c_pkg::*;
#(
    parameter int          CMD_DEPTH     = 8,
    parameter int          RX_DEPTH      = 8,
    parameter logic [15:0] CLK_DIV_RST   = 16'd250,
    parameter bit          ABORT_ON_NACK = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_s0_address,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic        avs_s0_irq,
    output logic [15:0] clk_div,
    output logic        core_start,
    output logic        core_stop,
    output logic        core_write,
    output logic        core_read_ack,
    output logic        core_read_nack,
    output logic [7:0]  core_txdata,
    input  logic [7:0]  core_rxdata,
    input  logic        core_buzy,
    input  logic        core_ack_fail,
    input  logic        core_rx_done,
    input  logic        core_tx_done,
    input  logic        core_start_done,
    input  logic        core_stop_done
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    seq_state_e  r_state;
    op_e         r_op;
    logic [15:0] r_clk_div;
    logic [7:0]  r_irq_en;
    logic        r_ack_fail, r_cmd_done, r_rx_ovf, r_cmd_ovf, r_bad_op, r_irq;
    logic        r_core_start, r_core_stop, r_core_write, r_core_rack, r_core_rnack;
    logic [7:0]  r_core_txdata;

    logic        w_wr_cmd, w_wr_clkdiv, w_wr_ctrl, w_wr_status, w_wr_irqen;
    logic        w_op_ok, w_op_bad, w_nack;
    logic        w_cmd_push, w_cmd_pop, w_cmd_flush, w_cmd_full, w_cmd_empty, w_cmd_ovf_set;
    logic [10:0] w_cmd_head;
    logic [CAW:0] w_cmd_level;
    op_e         w_head_op;
    logic        w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty, w_rx_ovf_set;
    logic [7:0]  w_rx_head;
    logic [RAW:0] w_rx_level;
    logic        w_done_match, w_cmd_done_set;
    logic [7:0]  w_clr;
    logic [31:0] w_status;

    assign w_wr_cmd    = avs_s0_write && (avs_s0_address == REG_CMD);
    assign w_wr_clkdiv = avs_s0_write && (avs_s0_address == REG_CLKDIV);
    assign w_wr_ctrl   = avs_s0_write && (avs_s0_address == REG_CONTROL);
    assign w_wr_status = avs_s0_write && (avs_s0_address == REG_STATUS);
    assign w_wr_irqen  = avs_s0_write && (avs_s0_address == REG_IRQEN);

    assign w_op_ok       = op_valid(avs_s0_writedata[10:8]);
    assign w_op_bad      = w_wr_cmd && !w_op_ok;
    assign w_nack        = core_tx_done && core_ack_fail;
    assign w_cmd_flush   = (w_wr_ctrl && avs_s0_writedata[0]) || (ABORT_ON_NACK && w_nack);
    assign w_cmd_push    = w_wr_cmd && w_op_ok && !w_cmd_full;
    assign w_cmd_ovf_set = w_wr_cmd && w_op_ok && w_cmd_full;
    assign w_cmd_pop     = (r_state == S_ISSUE);
    assign w_head_op     = op_e'(w_cmd_head[10:8]);

    assign w_rx_flush    = w_wr_ctrl && avs_s0_writedata[1];
    assign w_rx_pop      = avs_s0_read && (avs_s0_address == REG_RXDATA) && !w_rx_empty;
    assign w_rx_ovf_set  = core_rx_done && w_rx_full && !w_rx_pop;

    assign w_clr          = w_wr_status ? avs_s0_writedata[7:0] : 8'h00;
    assign w_cmd_done_set = (r_state == S_WAIT) && w_done_match && w_cmd_empty;

    sync_fifo #(.WIDTH(11), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_cmd_push),
        .pop     (w_cmd_pop),
        .flush   (w_cmd_flush),
        .din     (avs_s0_writedata[10:0]),
        .dout    (w_cmd_head),
        .full    (w_cmd_full),
        .empty   (w_cmd_empty),
        .level   (w_cmd_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (core_rx_done),
        .pop     (w_rx_pop),
        .flush   (w_rx_flush),
        .din     (core_rxdata),
        .dout    (w_rx_head),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .level   (w_rx_level)
    );

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_done_match = 1'b0;
        case (r_op)
            OP_START:         w_done_match = core_start_done;
            OP_STOP:          w_done_match = core_stop_done;
            OP_WRITE:         w_done_match = core_tx_done;
            OP_RACK, OP_RNACK: w_done_match = core_rx_done;
            default:          w_done_match = 1'b0;
        endcase
    end

    always_comb begin
        w_status                 = '0;
        w_status[ST_BUSY]        = (r_state != S_IDLE) || core_buzy;
        w_status[ST_ACK_FAIL]    = r_ack_fail;
        w_status[ST_CMD_DONE]    = r_cmd_done;
        w_status[ST_RX_NONEMPTY] = !w_rx_empty;
        w_status[ST_CMD_FULL]    = w_cmd_full;
        w_status[ST_RX_OVF]      = r_rx_ovf;
        w_status[ST_CMD_OVF]     = r_cmd_ovf;
        w_status[ST_BAD_OP]      = r_bad_op;
        w_status[15:8]           = 8'(w_cmd_level);
        w_status[23:16]          = 8'(w_rx_level);
    end

    always_comb begin
        avs_s0_readdata = '0;
        case (avs_s0_address)
            REG_RXDATA: if (!w_rx_empty) avs_s0_readdata[8:0] = {1'b1, w_rx_head};
            REG_CLKDIV: avs_s0_readdata[15:0] = r_clk_div;
            REG_STATUS: avs_s0_readdata = w_status;
            REG_IRQEN:  avs_s0_readdata[7:0] = r_irq_en;
            default:    ;
        endcase
    end

    // Pulses are registered on the IDLE->ISSUE edge so they are high exactly in ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_op          <= OP_START;
            r_core_start  <= 1'b0;
            r_core_stop   <= 1'b0;
            r_core_write  <= 1'b0;
            r_core_rack   <= 1'b0;
            r_core_rnack  <= 1'b0;
            r_core_txdata <= 8'h00;
        end else begin
            r_core_start <= 1'b0;
            r_core_stop  <= 1'b0;
            r_core_write <= 1'b0;
            r_core_rack  <= 1'b0;
            r_core_rnack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_cmd_empty && !core_buzy && !w_cmd_flush) begin
                        r_state <= S_ISSUE;
                        r_op    <= w_head_op;
                        case (w_head_op)
                            OP_START: r_core_start <= 1'b1;
                            OP_STOP:  r_core_stop  <= 1'b1;
                            OP_WRITE: begin
                                r_core_write  <= 1'b1;
                                r_core_txdata <= w_cmd_head[7:0];
                            end
                            OP_RACK:  r_core_rack  <= 1'b1;
                            OP_RNACK: r_core_rnack <= 1'b1;
                            default:  ;
                        endcase
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT:  if (w_done_match) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky bits: a set event in the same cycle as a W1C clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_div  <= CLK_DIV_RST;
            r_irq_en   <= 8'h00;
            r_ack_fail <= 1'b0;
            r_cmd_done <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_cmd_ovf  <= 1'b0;
            r_bad_op   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_clkdiv) r_clk_div <= avs_s0_writedata[15:0];
            if (w_wr_irqen)  r_irq_en  <= avs_s0_writedata[7:0];
            r_ack_fail <= (r_ack_fail & ~w_clr[ST_ACK_FAIL]) | w_nack;
            r_cmd_done <= (r_cmd_done & ~w_clr[ST_CMD_DONE]) | w_cmd_done_set;
            r_rx_ovf   <= (r_rx_ovf   & ~w_clr[ST_RX_OVF])   | w_rx_ovf_set;
            r_cmd_ovf  <= (r_cmd_ovf  & ~w_clr[ST_CMD_OVF])  | w_cmd_ovf_set;
            r_bad_op   <= (r_bad_op   & ~w_clr[ST_BAD_OP])   | w_op_bad;
            r_irq      <= |(w_status[7:1] & r_irq_en[7:1]);
        end
    end

    assign avs_s0_irq     = r_irq;
    assign clk_div        = r_clk_div;
    assign core_start     = r_core_start;
    assign core_stop      = r_core_stop;
    assign core_write     = r_core_write;
    assign core_read_ack  = r_core_rack;
    assign core_read_nack = r_core_rnack;
    assign core_txdata    = r_core_txdata;

endmodule
